// File: rtl/priv_op_sequencer.sv
// Privileged-op sequencer: runs one CSR/TLB/cache/ERTN/IDLE op at a time and returns
// a result plus pipeline flush requests to writeback.
module priv_op_sequencer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CSR_ADDR_W = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [3:0]            issue_op,
  input  logic [CSR_ADDR_W-1:0] issue_csr,
  input  logic [DATA_W-1:0]     issue_rj,
  input  logic [DATA_W-1:0]     issue_rd,
  input  logic [4:0]            issue_imm5,
  output logic                  csr_re,
  output logic                  csr_we,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic [DATA_W-1:0]     csr_wdata,
  input  logic [DATA_W-1:0]     csr_rdata,
  output logic                  tlb_req,
  output logic [3:0]            tlb_op,
  input  logic                  tlb_done,
  output logic                  cacop_req,
  input  logic                  cacop_done,
  input  logic                  irq_pending,
  input  logic                  kill,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_W-1:0]     res_data,
  output logic                  res_err,
  output logic                  flush_req,
  output logic                  ertn_flush
);

  // csr_op_type codes as produced by the CSR decoder
  localparam logic [3:0] OP_CSRRD   = 4'd0;
  localparam logic [3:0] OP_CSRWR   = 4'd1;
  localparam logic [3:0] OP_CSRXCHG = 4'd2;
  localparam logic [3:0] OP_CACOP   = 4'd3;
  localparam logic [3:0] OP_TLBSRCH = 4'd4;
  localparam logic [3:0] OP_TLBRD   = 4'd5;
  localparam logic [3:0] OP_TLBWR   = 4'd6;
  localparam logic [3:0] OP_TLBFILL = 4'd7;
  localparam logic [3:0] OP_INVTLB  = 4'd8;
  localparam logic [3:0] OP_ERTN    = 4'd9;
  localparam logic [3:0] OP_IDLE    = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE, S_RD, S_CAP, S_WR, S_TLB, S_CAC, S_WAIT, S_FLUSH, S_RESP
  } state_t;

  state_t                state, state_nx;
  logic [3:0]            op_q;
  logic [CSR_ADDR_W-1:0] csr_q;
  logic [DATA_W-1:0]     rj_q, rd_q, old_q;
  logic [4:0]            imm_q;
  logic                  killed_q;
  logic                  accept;

  function automatic logic is_csr_op(input logic [3:0] op);
    return op inside {OP_CSRRD, OP_CSRWR, OP_CSRXCHG};
  endfunction

  function automatic logic is_tlb_op(input logic [3:0] op);
    return op inside {OP_TLBSRCH, OP_TLBRD, OP_TLBWR, OP_TLBFILL, OP_INVTLB};
  endfunction

  function automatic logic is_invalid_op(input logic [3:0] op);
    return op > OP_IDLE;
  endfunction

  assign accept = issue_valid && (state == S_IDLE);

  // INVTLB/CACOP sub-op is latched with the op but not consumed by the sequencer
  logic unused_imm;
  assign unused_imm = ^imm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      csr_q    <= '0;
      rj_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      old_q    <= '0;
      killed_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q  <= issue_op;
        csr_q <= issue_csr;
        rj_q  <= issue_rj;
        rd_q  <= issue_rd;
        imm_q <= issue_imm5;
      end
      if (state == S_CAP) old_q <= csr_rdata;
      // a kill during an outstanding TLB/cache request is remembered until done
      if (state == S_TLB || state == S_CAC) killed_q <= killed_q | kill;
      else killed_q <= 1'b0;
    end
  end

  always_comb begin
    state_nx    = state;
    issue_ready = 1'b0;
    csr_re      = 1'b0;
    csr_we      = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
    tlb_req     = 1'b0;
    tlb_op      = '0;
    cacop_req   = 1'b0;
    res_valid   = 1'b0;
    res_data    = '0;
    res_err     = 1'b0;
    flush_req   = 1'b0;
    ertn_flush  = 1'b0;
    case (state)
      S_IDLE: begin
        issue_ready = 1'b1;
        if (accept) begin
          if (is_csr_op(issue_op))      state_nx = S_RD;
          else if (is_tlb_op(issue_op)) state_nx = S_TLB;
          else if (issue_op == OP_CACOP) state_nx = S_CAC;
          else if (issue_op == OP_ERTN)  state_nx = S_FLUSH;
          else if (issue_op == OP_IDLE)  state_nx = S_WAIT;
          else                           state_nx = S_RESP;
        end
      end
      S_RD: begin
        csr_re   = 1'b1;
        csr_addr = csr_q;
        state_nx = kill ? S_IDLE : S_CAP;
      end
      S_CAP: begin
        if (kill)                  state_nx = S_IDLE;
        else if (op_q == OP_CSRRD) state_nx = S_RESP;
        else                       state_nx = S_WR;
      end
      S_WR: begin
        csr_we    = !kill;
        csr_addr  = csr_q;
        csr_wdata = (op_q == OP_CSRXCHG) ? ((old_q & ~rj_q) | (rd_q & rj_q)) : rd_q;
        state_nx  = kill ? S_IDLE : S_FLUSH;
      end
      S_TLB: begin
        tlb_req = 1'b1;
        tlb_op  = op_q;
        if (tlb_done) state_nx = (killed_q || kill) ? S_IDLE : S_FLUSH;
      end
      S_CAC: begin
        cacop_req = 1'b1;
        if (cacop_done) state_nx = (killed_q || kill) ? S_IDLE : S_RESP;
      end
      S_WAIT: begin
        if (kill)             state_nx = S_IDLE;
        else if (irq_pending) state_nx = S_RESP;
      end
      S_FLUSH: begin
        flush_req  = !kill;
        ertn_flush = !kill && (op_q == OP_ERTN);
        state_nx   = kill ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        if (!kill) begin
          res_valid = 1'b1;
          res_data  = is_csr_op(op_q) ? old_q : '0;
          res_err   = is_invalid_op(op_q);
        end
        if (kill || res_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_priv_op_sequencer.sv
// Self-checking bench for priv_op_sequencer: directed spec scenarios, kill/reset cases
// and randomized ops checked against a cycle-schedule model of each op type.
module tb_priv_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_ready;
  logic [3:0]  issue_op;
  logic [13:0] issue_csr;
  logic [31:0] issue_rj, issue_rd;
  logic [4:0]  issue_imm5;
  logic        csr_re, csr_we;
  logic [13:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        tlb_req;
  logic [3:0]  tlb_op;
  logic        tlb_done, cacop_req, cacop_done, irq_pending, kill;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        res_err, flush_req, ertn_flush;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  priv_op_sequencer #(.DATA_W(32), .CSR_ADDR_W(14)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_csr(issue_csr), .issue_rj(issue_rj), .issue_rd(issue_rd), .issue_imm5(issue_imm5),
    .csr_re(csr_re), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .tlb_req(tlb_req), .tlb_op(tlb_op), .tlb_done(tlb_done),
    .cacop_req(cacop_req), .cacop_done(cacop_done), .irq_pending(irq_pending), .kill(kill),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .flush_req(flush_req), .ertn_flush(ertn_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ctl();
    return {issue_ready, csr_re, csr_we, tlb_req, cacop_req, flush_req, ertn_flush,
            res_valid, res_err};
  endfunction

  function automatic logic [63:0] strobes();
    return {csr_re, csr_we, csr_addr, csr_wdata, tlb_req, tlb_op, cacop_req, res_valid,
            res_err, flush_req, ertn_flush};
  endfunction

  task automatic idle_inputs();
    issue_valid = 1'b0; tlb_done = 1'b0; cacop_done = 1'b0; irq_pending = 1'b0;
    kill = 1'b0; res_ready = 1'b0; csr_rdata = $urandom;
  endtask

  // present an op on the negedge; returns at posedge+1 of cycle 1
  task automatic issue(input logic [3:0] op, input logic [13:0] csr,
                       input logic [31:0] rj, input logic [31:0] rd);
    @(negedge clk);
    chk("issue_ready before accept", {63'd0, issue_ready}, 64'd1);
    issue_valid = 1'b1; issue_op = op; issue_csr = csr; issue_rj = rj; issue_rd = rd;
    issue_imm5 = 5'($urandom);
    @(posedge clk); #1;
    issue_valid = 1'b0; issue_op = 4'($urandom); issue_csr = 14'($urandom);
    issue_rj = $urandom; issue_rd = $urandom;
  endtask

  // d: tlb_done/cacop_done cycle or irq cycle; rdy: first cycle res_ready is high
  task automatic run_op(input logic [3:0] op, input logic [13:0] csr, input logic [31:0] rj,
                        input logic [31:0] rd, input logic [31:0] rdata,
                        input int unsigned d, input int unsigned rdy, input bit noise);
    bit is_csr, is_tlb, is_cac, is_ertn, is_idle, is_inv;
    int unsigned we_cyc, fl_cyc, resp, hs;
    logic [31:0] exp_wdata, exp_res;
    logic [8:0] exp;
    is_csr = op <= 4'd2; is_cac = op == 4'd3; is_tlb = op >= 4'd4 && op <= 4'd8;
    is_ertn = op == 4'd9; is_idle = op == 4'd10; is_inv = op >= 4'd11;
    we_cyc = 0; fl_cyc = 0;
    if (is_csr) begin
      resp = (op == 4'd0) ? 3 : 5;
      if (op != 4'd0) begin we_cyc = 3; fl_cyc = 4; end
    end else if (is_tlb) begin fl_cyc = d + 1; resp = d + 2; end
    else if (is_cac)  resp = d + 1;
    else if (is_ertn) begin fl_cyc = 1; resp = 2; end
    else if (is_idle) resp = d + 1;
    else              resp = 1;
    hs = (rdy > resp) ? rdy : resp;
    exp_wdata = (op == 4'd2) ? ((rdata & ~rj) | (rd & rj)) : rd;
    exp_res   = is_csr ? rdata : 32'd0;
    issue(op, csr, rj, rd);
    for (int unsigned k = 1; k <= hs + 1; k++) begin
      csr_rdata   = (is_csr && k == 2) ? rdata : $urandom;
      tlb_done    = is_tlb ? (k == d) : (noise ? 1'($urandom) : 1'b0);
      cacop_done  = is_cac ? (k == d) : (noise ? 1'($urandom) : 1'b0);
      irq_pending = is_idle ? (k >= d) : (noise ? 1'($urandom) : 1'b0);
      res_ready   = (k >= rdy);
      @(negedge clk);
      exp = {k > hs, is_csr && k == 1, we_cyc != 0 && k == we_cyc, is_tlb && k <= d,
             is_cac && k <= d, fl_cyc != 0 && k == fl_cyc, is_ertn && k == 1,
             k >= resp && k <= hs, is_inv && k >= resp && k <= hs};
      chk($sformatf("op%0h ctl k=%0d", op, k), {55'd0, ctl()}, {55'd0, exp});
      if (exp[7] || exp[6]) chk($sformatf("op%0h csr_addr k=%0d", op, k), {50'd0, csr_addr}, {50'd0, csr});
      if (exp[6]) chk($sformatf("op%0h csr_wdata", op), {32'd0, csr_wdata}, {32'd0, exp_wdata});
      if (exp[5]) chk($sformatf("op%0h tlb_op k=%0d", op, k), {60'd0, tlb_op}, {60'd0, op});
      if (exp[1]) chk($sformatf("op%0h res_data k=%0d", op, k), {32'd0, res_data}, {32'd0, exp_res});
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    issue_op = '0; issue_csr = '0; issue_rj = '0; issue_rd = '0; issue_imm5 = '0;
    idle_inputs();
    @(negedge clk);
    chk("reset strobes", strobes(), 64'd0);
    chk("reset res_data", {32'd0, res_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed scenarios from the op descriptions
    run_op(4'd0, 14'h005, $urandom, $urandom, 32'h0000_1234, 0, 3, 1'b0);
    run_op(4'd2, 14'h040, 32'h0000_FFFF, 32'h1234_5678, 32'hFF00_FF00, 0, 5, 1'b0);
    run_op(4'd1, 14'h011, $urandom, 32'hCAFE_F00D, 32'h0BAD_BEEF, 0, 8, 1'b1);
    run_op(4'd4, 14'h000, 0, 0, 0, 7, 0, 1'b0);
    run_op(4'd10, 14'h000, 0, 0, 0, 20, 25, 1'b0);
    run_op(4'hF, 14'h000, 0, 0, 0, 0, 1, 1'b0);
    run_op(4'd9, 14'h000, 0, 0, 0, 0, 2, 1'b1);
    run_op(4'd3, 14'h000, 0, 0, 0, 1, 0, 1'b1);
    run_op(4'd8, 14'h000, 0, 0, 0, 1, 0, 1'b1);

    // CACOP killed mid-wait: request held to cacop_done, then silently back to idle
    issue(4'd3, 14'h0, 0, 0);
    for (int unsigned k = 1; k <= 8; k++) begin
      kill = (k == 3); cacop_done = (k == 6); res_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("cacop kill k=%0d", k), {60'd0, cacop_req, res_valid, flush_req, issue_ready},
          {60'd0, k <= 6, 1'b0, 1'b0, k >= 7});
      @(posedge clk); #1;
    end
    idle_inputs();

    // CSRWR killed in the write cycle: no csr_we, no flush, no response
    issue(4'd1, 14'h022, 0, 32'h5555_AAAA);
    for (int unsigned k = 1; k <= 5; k++) begin
      kill = (k == 3); csr_rdata = $urandom; res_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("csrwr kill k=%0d", k), {59'd0, csr_re, csr_we, flush_req, res_valid, issue_ready},
          {59'd0, k == 1, 1'b0, 1'b0, 1'b0, k >= 4});
      @(posedge clk); #1;
    end
    idle_inputs();

    // INVTLB killed while waiting on the TLB
    issue(4'd8, 14'h0, $urandom, $urandom);
    for (int unsigned k = 1; k <= 6; k++) begin
      kill = (k == 2); tlb_done = (k == 4); res_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("invtlb kill k=%0d", k), {60'd0, tlb_req, flush_req, res_valid, issue_ready},
          {60'd0, k <= 4, 1'b0, 1'b0, k >= 5});
      @(posedge clk); #1;
    end
    idle_inputs();

    // kill beats irq_pending in the wait state
    issue(4'd10, 14'h0, 0, 0);
    for (int unsigned k = 1; k <= 5; k++) begin
      kill = (k == 3); irq_pending = (k == 3); res_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("idle kill k=%0d", k), {62'd0, res_valid, issue_ready}, {62'd0, 1'b0, k >= 4});
      @(posedge clk); #1;
    end
    idle_inputs();

    // kill beats res_ready in the response state; kill in ERTN flush
    issue(4'hF, 14'h0, 0, 0);
    kill = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    chk("invalid kill resp", {61'd0, res_valid, res_err, issue_ready}, 64'd0);
    @(posedge clk); #1;
    idle_inputs();
    issue(4'd9, 14'h0, 0, 0);
    kill = 1'b1;
    @(negedge clk);
    chk("ertn kill flush", {61'd0, flush_req, ertn_flush, res_valid}, 64'd0);
    @(posedge clk); #1;
    idle_inputs();

    // reset pulse while CSRWR is reading its CSR
    issue(4'd1, 14'h033, 0, $urandom);
    @(negedge clk);
    chk("csrwr rd before reset", {63'd0, csr_re}, 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("strobes during reset", strobes(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd0, 14'h077, 0, 0, 32'h8765_4321, 0, 1, 1'b0);

    // randomized ops
    for (int i = 0; i < 40; i++) begin
      run_op(4'($urandom), 14'($urandom), $urandom, $urandom, $urandom,
             $urandom_range(1, 6), $urandom_range(0, 8), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
